// File: rtl/scene_if.sv
// Scene controller bus: scene inputs from the renderers/datapath, VGA pixel and scene status outputs.
interface scene_if;
    logic       frame_tick;
    logic       video_on;
    logic       start_btn;
    logic       hit;
    logic [2:0] title_rgb;
    logic [2:0] play_rgb;
    logic [2:0] over_rgb;
    logic       vga_R;
    logic       vga_G;
    logic       vga_B;
    logic [1:0] scene;
    logic       play_en;

    modport master (
        output frame_tick, video_on, start_btn, hit, title_rgb, play_rgb, over_rgb,
        input  vga_R, vga_G, vga_B, scene, play_en
    );

    modport slave (
        input  frame_tick, video_on, start_btn, hit, title_rgb, play_rgb, over_rgb,
        output vga_R, vga_G, vga_B, scene, play_en
    );
endinterface

// File: rtl/scene_controller.sv
// TITLE -> PLAY -> FREEZE -> OVER scene sequencer with frame timeouts,
// game-over text blink and registered per-scene RGB mux.
module scene_controller #(
    parameter int CNT_W         = 8,
    parameter int FREEZE_FRAMES = 30,
    parameter int OVER_FRAMES   = 180,
    parameter int BLINK_FRAMES  = 30
) (
    input  logic    clk,
    input  logic    reset,
    scene_if.slave  bus
);
    typedef enum logic [1:0] {
        TITLE  = 2'b00,
        PLAY   = 2'b01,
        FREEZE = 2'b10,
        OVER   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] FREEZE_LAST = CNT_W'(FREEZE_FRAMES - 1);
    localparam logic [CNT_W-1:0] OVER_LAST   = CNT_W'(OVER_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_FRAMES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] frame_cnt, frame_n;
    logic [CNT_W-1:0] blink_cnt, blink_n;
    logic             text_vis, vis_n;
    logic             start_q;
    logic             start_rise;
    logic [2:0]       rgb_q, rgb_n;

    // start_q resets high so a button held through reset is not seen as a press
    assign start_rise = bus.start_btn & ~start_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= TITLE;
            frame_cnt <= '0;
            blink_cnt <= '0;
            text_vis  <= 1'b1;
            start_q   <= 1'b1;
            rgb_q     <= 3'b000;
        end else begin
            state     <= state_n;
            frame_cnt <= frame_n;
            blink_cnt <= blink_n;
            text_vis  <= vis_n;
            start_q   <= bus.start_btn;
            rgb_q     <= rgb_n;
        end
    end

    always_comb begin
        state_n = state;
        frame_n = frame_cnt;
        blink_n = blink_cnt;
        vis_n   = text_vis;
        case (state)
            TITLE: begin
                frame_n = '0;
                if (start_rise) state_n = PLAY;
            end
            PLAY: begin
                frame_n = '0;
                if (bus.hit) state_n = FREEZE;
            end
            FREEZE: begin
                if (bus.frame_tick) begin
                    if (frame_cnt == FREEZE_LAST) begin
                        state_n = OVER;
                        frame_n = '0;
                        blink_n = '0;
                        vis_n   = 1'b1;
                    end else begin
                        frame_n = frame_cnt + 1'b1;
                    end
                end
            end
            OVER: begin
                if (bus.frame_tick) begin
                    if (blink_cnt == BLINK_LAST) begin
                        blink_n = '0;
                        vis_n   = ~text_vis;
                    end else begin
                        blink_n = blink_cnt + 1'b1;
                    end
                    if (frame_cnt == OVER_LAST) begin
                        state_n = TITLE;
                        frame_n = '0;
                    end else begin
                        frame_n = frame_cnt + 1'b1;
                    end
                end
                // a restart wins over a timeout landing in the same cycle
                if (start_rise) begin
                    state_n = PLAY;
                    frame_n = '0;
                end
            end
            default: state_n = TITLE;
        endcase
    end

    // Source follows the current state register, so a scene change switches cleanly on the next pixel
    always_comb begin
        rgb_n = 3'b000;
        if (bus.video_on) begin
            case (state)
                TITLE:       rgb_n = bus.title_rgb;
                PLAY,FREEZE: rgb_n = bus.play_rgb;
                OVER:        rgb_n = text_vis ? bus.over_rgb : 3'b000;
                default:     rgb_n = 3'b000;
            endcase
        end
    end

    assign bus.vga_R   = rgb_q[2];
    assign bus.vga_G   = rgb_q[1];
    assign bus.vga_B   = rgb_q[0];
    assign bus.scene   = state;
    assign bus.play_en = (state == PLAY);
endmodule

// File: tb/tb_scene_controller.sv
// Directed bench for scene_controller with short timeouts (freeze 2, over 6, blink 2).
module tb_scene_controller;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    scene_if sif();

    scene_controller #(
        .CNT_W(8), .FREEZE_FRAMES(2), .OVER_FRAMES(6), .BLINK_FRAMES(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [2:0] vga();
        return {sif.vga_R, sif.vga_G, sif.vga_B};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sif.frame_tick = 1'b1;
        step();
        sif.frame_tick = 1'b0;
    endtask

    task automatic press();
        sif.start_btn = 1'b0;
        step();
        sif.start_btn = 1'b1;
        step();
    endtask

    task automatic do_hit();
        sif.hit = 1'b1;
        step();
        sif.hit = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        sif.frame_tick = 1'b0;
        sif.video_on   = 1'b1;
        sif.start_btn  = 1'b1;
        sif.hit        = 1'b0;
        sif.title_rgb  = 3'b010;
        sif.play_rgb   = 3'b101;
        sif.over_rgb   = 3'b111;
        step();
        step();
        chk("rst_scene", 8'(sif.scene), 8'h0);
        chk("rst_play_en", 8'(sif.play_en), 8'h0);
        chk("rst_vga", 8'(vga()), 8'h0);

        // Held button through reset must not start
        reset = 1'b0;
        step(); step(); step();
        chk("held_no_start", 8'(sif.scene), 8'h0);

        press();
        chk("start_scene", 8'(sif.scene), 8'h1);
        chk("start_play_en", 8'(sif.play_en), 8'h1);
        chk("title_pixel_at_switch", 8'(vga()), 8'h2);
        step();
        chk("play_pixel", 8'(vga()), 8'h5);
        sif.video_on = 1'b0;
        step();
        chk("blank_pixel", 8'(vga()), 8'h0);
        sif.video_on = 1'b1;
        step();
        chk("play_pixel_again", 8'(vga()), 8'h5);

        do_hit();
        chk("freeze_scene", 8'(sif.scene), 8'h2);
        chk("freeze_play_en", 8'(sif.play_en), 8'h0);
        step();
        chk("freeze_pixel", 8'(vga()), 8'h5);
        tick();
        chk("one_tick_stays_freeze", 8'(sif.scene), 8'h2);
        tick();
        chk("over_scene", 8'(sif.scene), 8'h3);

        // Blink: on 2 frames, off 2, on 2, then timeout to TITLE
        for (int f = 0; f < 6; f++) begin
            step();
            chk($sformatf("blink_f%0d", f), 8'(vga()), (f < 2 || f >= 4) ? 8'h7 : 8'h0);
            chk($sformatf("over_hold_f%0d", f), 8'(sif.scene), 8'h3);
            tick();
        end
        chk("over_timeout", 8'(sif.scene), 8'h0);
        step();
        chk("title_pixel", 8'(vga()), 8'h2);

        // hit coincident with TITLE->PLAY is ignored
        sif.start_btn = 1'b0;
        step();
        sif.start_btn = 1'b1;
        sif.hit = 1'b1;
        step();
        sif.hit = 1'b0;
        chk("hit_on_start_ignored", 8'(sif.scene), 8'h1);
        step();
        chk("still_play", 8'(sif.scene), 8'h1);

        // Restart coincident with the final OVER tick wins
        sif.start_btn = 1'b0;
        do_hit();
        tick(); tick();
        chk("over_again", 8'(sif.scene), 8'h3);
        for (int f = 0; f < 5; f++) tick();
        chk("over_before_last", 8'(sif.scene), 8'h3);
        sif.start_btn = 1'b1;
        tick();
        chk("restart_priority", 8'(sif.scene), 8'h1);
        chk("restart_frame_cnt", 8'(dut.frame_cnt), 8'h0);
        do_hit();
        tick();
        chk("freeze_after_restart", 8'(sif.scene), 8'h2);
        tick();

        // Asynchronous reset mid-OVER while the text is lit
        step();
        chk("over_lit", 8'(vga()), 8'h7);
        #2;
        reset = 1'b1;
        #1;
        chk("async_vga", 8'(vga()), 8'h0);
        chk("async_scene", 8'(sif.scene), 8'h0);
        chk("async_play_en", 8'(sif.play_en), 8'h0);
        step();
        reset = 1'b0;
        sif.start_btn = 1'b0;
        step();
        sif.start_btn = 1'b1;
        step();
        chk("post_reset_start", 8'(sif.scene), 8'h1);
        do_hit();
        tick(); tick();
        chk("reenter_over", 8'(sif.scene), 8'h3);
        chk("reenter_text_vis", 8'(dut.text_vis), 8'h1);
        step();
        chk("reenter_lit", 8'(vga()), 8'h7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/scene_controller.md
# scene_controller

Sequencer for the screen scenes of the game. It owns the TITLE → PLAY → FREEZE → OVER flow, counts frames for the hit-freeze and game-over timeouts, and blinks the game-over text. It selects which scene renderer's 1-bit R/G/B drives the VGA pins. It sits between the per-scene renderers (title, play field, game-over text) and the VGA sync generator's `CounterX`/`CounterY` domain, and gates the game datapath through `play_en`.

## Interface
Parameters:
- `CNT_W`, 8: width of the frame and blink counters.
- `FREEZE_FRAMES`, 30: frames the play field is held still after a hit. Range 1..2^CNT_W.
- `OVER_FRAMES`, 180: frames the game-over scene is shown before returning to TITLE. Range 1..2^CNT_W.
- `BLINK_FRAMES`, 30: frames per on/off phase of the game-over text. Range 1..2^CNT_W.

Ports:
- `clk`, in, 1: pixel clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `frame_tick`, in, 1: one-cycle pulse once per frame, at the start of vertical blank.
- `video_on`, in, 1: high while `CounterX`/`CounterY` are inside the visible area.
- `start_btn`, in, 1: start button level, already synchronized to `clk`.
- `hit`, in, 1: collision pulse from the game datapath.
- `title_rgb`, in, 3: {R,G,B} from the title renderer.
- `play_rgb`, in, 3: {R,G,B} from the play-field renderer.
- `over_rgb`, in, 3: {R,G,B} from the game-over text renderer.
- `vga_R`, `vga_G`, `vga_B`, out, 1 each: registered pixel outputs.
- `scene`, out, 2: current state encoding.
- `play_en`, out, 1: high only in PLAY; enables motion and scoring in the datapath.

## Operation
State encoding is TITLE=2'b00, PLAY=2'b01, FREEZE=2'b10, OVER=2'b11. `scene` equals the state register.

Start edge:
- `start_q` is a register of `start_btn`.
- `start_rise = start_btn & ~start_q`.
- `start_q` resets to 1, so a button held through reset does not start a game.

Transitions (all other inputs are ignored in each state):
- TITLE: `start_rise` → PLAY. `frame_cnt` ← 0.
- PLAY: `hit` → FREEZE. `frame_cnt` ← 0.
- FREEZE:
  - Each `frame_tick` increments `frame_cnt`.
  - A `frame_tick` arriving while `frame_cnt == FREEZE_FRAMES-1` moves to OVER, with `frame_cnt` ← 0, `blink_cnt` ← 0, `text_vis` ← 1.
- OVER:
  - Each `frame_tick` increments `frame_cnt`.
  - A `frame_tick` arriving while `frame_cnt == OVER_FRAMES-1` moves to TITLE with `frame_cnt` ← 0.
  - `start_rise` moves to PLAY with `frame_cnt` ← 0, and takes priority over the timeout in the same cycle.

Blink (OVER only):
- Each `frame_tick` increments `blink_cnt`.
- At `blink_cnt == BLINK_FRAMES-1` with `frame_tick`, `blink_cnt` ← 0 and `text_vis` toggles.

Counter rules:
- Counters never exceed their compare value.
- `frame_cnt` holds at 0 outside FREEZE and OVER.

Pixel mux, selected by the current state register:
- TITLE: `title_rgb`.
- PLAY and FREEZE: `play_rgb`.
- OVER: `text_vis ? over_rgb : 3'b000`.
- Any state with `video_on = 0`: 3'b000.

`play_en = (state == PLAY)`, driven directly from the state register.

Reset values: state TITLE, `frame_cnt` 0, `blink_cnt` 0, `text_vis` 1, `start_q` 1, `vga_R`/`vga_G`/`vga_B` 0, `scene` 2'b00, `play_en` 0.

## Timing
- Pixel latency is 1 cycle: `video_on` and `*_rgb` sampled at edge n appear on `vga_*` after edge n.
- The renderers must be fed `CounterX`/`CounterY` delayed to match this cycle.
- State change latency is 1 cycle: the qualifying input is sampled at edge n, and the new `scene` and `play_en` are valid after edge n.
- The mux switches source on the first pixel after the state change. The old source is never mixed in.
- A `hit` in the same cycle as the TITLE→PLAY transition is ignored, because the state was not yet PLAY.
- FREEZE lasts exactly `FREEZE_FRAMES` `frame_tick` pulses. OVER lasts exactly `OVER_FRAMES` pulses unless a restart occurs.
- Blink phase length is exactly `BLINK_FRAMES` pulses.
- `reset` asserted mid-frame: all outputs go to their reset values immediately, without waiting for a clock edge. Operation resumes on the first `clk` edge after deassertion.

## Test plan
Use `FREEZE_FRAMES=2`, `OVER_FRAMES=6`, `BLINK_FRAMES=2`, with `video_on=1` unless stated.

1. Reset with `start_btn=1` held, then release reset → `scene` stays 2'b00. A release followed by a new press (0→1) → `scene`=01 and `play_en`=1 one cycle after the rising sample.
2. In PLAY, with `play_rgb=3'b101` and `title_rgb=3'b010` → `vga_*`=101 one cycle later. Set `video_on=0` → `vga_*`=000 one cycle later.
3. Pulse `hit` in PLAY → `scene`=10 and `play_en`=0 next cycle. After the 2nd `frame_tick` → `scene`=11. A single `frame_tick` in FREEZE does not leave FREEZE.
4. In OVER with `over_rgb=3'b111` → `vga_*` reads 111 for 2 frames, then 000 for 2, then 111 for 2. After the 6th `frame_tick` → `scene`=00.
5. In OVER, assert `start_rise` and the 6th `frame_tick` in the same cycle → `scene`=01, not 00. `frame_cnt` is 0.
6. Assert `reset` mid-OVER while `vga_*`=111 → `vga_*`=000 and `scene`=00 before the next `clk` edge. `text_vis` is 1 on the next entry to OVER.
